// File: rtl/jtag_uart_receiver.sv
// Avalon-MM master that polls the JTAG UART data register and pops received
// characters into a small FIFO, presented downstream as an 8-bit Avalon-ST source.
module jtag_uart_receiver #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned POLL_GAP = 16
) (
   input  logic                       clock,
   input  logic                       reset_n,
   output logic                       read,
   output logic                       write,
   output logic [2:0]                 address,
   output logic                       chipselect,
   output logic [3:0]                 byteenable,
   output logic [31:0]                writedata,
   input  logic [31:0]                readdata,
   input  logic                       waitrequest,
   output logic [7:0]                 av_src_data,
   output logic                       av_src_valid,
   input  logic                       av_src_ready,
   output logic [1:0]                 av_src_error,
   output logic [$clog2(DEPTH):0]     fill_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ_WAIT,
      S_GAP
   } state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      mem_q [DEPTH];

   logic            accept;
   logic            push;
   logic            pop;
   logic            unused_readdata;

   // RAVAIL and the reserved data-register bits carry no control meaning here.
   assign unused_readdata = ^{readdata[31:16], readdata[14:8]};

   assign accept = (state_q == S_READ_WAIT) && !waitrequest;
   assign push   = accept && readdata[15];
   assign pop    = (count_q != '0) && av_src_ready;

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE: begin
            // Every read pops a UART character, so only poll with a free slot.
            if (count_q < CW'(DEPTH)) begin
               state_d = S_READ_WAIT;
            end
         end
         S_READ_WAIT: begin
            if (accept) begin
               if (readdata[15]) begin
                  state_d = S_IDLE;
               end else begin
                  gap_d   = GW'(POLL_GAP - 1);
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         gap_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         gap_q    <= gap_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= readdata[7:0];
      end
   end

   assign read         = (state_q == S_READ_WAIT);
   assign write        = 1'b0;
   assign address      = 3'b000;
   assign chipselect   = 1'b1;
   assign byteenable   = 4'b1111;
   assign writedata    = '0;
   assign av_src_data  = mem_q[rd_ptr_q];
   assign av_src_valid = (count_q != '0);
   assign av_src_error = 2'b00;
   assign fill_level   = count_q;

endmodule

// File: tb/tb_jtag_uart_receiver.sv
// Directed bench for jtag_uart_receiver: a per-cycle vector table for the basic
// receive and wait-state flows, plus hand sequences for full, wrap, polling and reset.
module tb_jtag_uart_receiver;

   logic        clock;
   logic        reset_n;
   logic        read;
   logic        write;
   logic [2:0]  address;
   logic        chipselect;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        waitrequest;
   logic [7:0]  av_src_data;
   logic        av_src_valid;
   logic        av_src_ready;
   logic [1:0]  av_src_error;
   logic [2:0]  fill_level;

   jtag_uart_receiver #(.DEPTH(4), .POLL_GAP(16)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .read         (read),
      .write        (write),
      .address      (address),
      .chipselect   (chipselect),
      .byteenable   (byteenable),
      .writedata    (writedata),
      .readdata     (readdata),
      .waitrequest  (waitrequest),
      .av_src_data  (av_src_data),
      .av_src_valid (av_src_valid),
      .av_src_ready (av_src_ready),
      .av_src_error (av_src_error),
      .fill_level   (fill_level)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] rd;
      logic        wr;
      logic        rdy;
      logic        e_read;
      logic        e_valid;
      logic [7:0]  e_data;
      logic [2:0]  e_fill;
   } vec_t;

   vec_t tbl[$];

   // Scripted slave state: byte counter, pending-accept flag, accepted-read count.
   logic [7:0] sb;
   bit         pending;
   bit         rv;
   int         acc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [31:0] rd, input logic wr, input logic rdy,
                               input logic e_read, input logic e_valid,
                               input logic [7:0] e_data, input logic [2:0] e_fill);
      vec_t v;
      v.rd = rd; v.wr = wr; v.rdy = rdy;
      v.e_read = e_read; v.e_valid = e_valid; v.e_data = e_data; v.e_fill = e_fill;
      tbl.push_back(v);
   endfunction

   task automatic do_reset(input logic [7:0] sb_init, input bit rv_init);
      reset_n      = 1'b0;
      readdata     = 32'h0;
      waitrequest  = 1'b0;
      av_src_ready = 1'b0;
      sb = sb_init; pending = 0; rv = rv_init; acc = 0;
      repeat (2) @(negedge clock);
      chk("rst_read", read, 0);
      chk("rst_valid", av_src_valid, 0);
      chk("rst_fill", fill_level, 0);
      chk("rst_write", write, 0);
      chk("rst_address", address, 0);
      chk("rst_chipselect", chipselect, 1);
      chk("rst_byteenable", byteenable, 4'hF);
      chk("rst_writedata", writedata, 0);
      chk("rst_error", av_src_error, 0);
      reset_n = 1'b1;
   endtask

   task automatic slave_cycle();
      @(negedge clock);
      if (pending) begin
         sb = sb + 8'd1;
         pending = 0;
      end
      readdata = rv ? {16'h0001, 8'h80, sb} : 32'h0;
      if (read && !waitrequest) begin
         pending = 1;
         acc++;
      end
   endtask

   initial begin
      logic [7:0] rec [20];
      int n;
      int guard;
      int starts;
      int last_start;
      int vcount;
      bit prev_read;
      bit found;

      // Basic receive, empty poll spacing, then a 5-cycle wait-state read.
      add(32'h0001_8041, 0, 1, 0, 0, 8'h00, 0);
      add(32'h0001_8041, 0, 1, 1, 0, 8'h00, 0);
      add(32'h0000_0000, 0, 1, 0, 1, 8'h41, 1);
      add(32'h0000_0000, 0, 1, 1, 0, 8'h00, 0);
      for (int i = 0; i < 16; i++) add(32'h0000_0000, 0, 1, 0, 0, 8'h00, 0);
      add(32'h0000_805A, 1, 1, 0, 0, 8'h00, 0);
      for (int i = 0; i < 5; i++) add(32'h0000_805A, 1, 1, 1, 0, 8'h00, 0);
      add(32'h0000_805A, 0, 1, 1, 0, 8'h00, 0);
      add(32'h0000_0000, 0, 1, 0, 1, 8'h5A, 1);
      add(32'h0000_0000, 0, 1, 1, 0, 8'h00, 0);

      do_reset(8'h00, 0);
      for (int i = 0; i < tbl.size(); i++) begin
         chk($sformatf("vec%0d_read", i), read, tbl[i].e_read);
         chk($sformatf("vec%0d_valid", i), av_src_valid, tbl[i].e_valid);
         chk($sformatf("vec%0d_fill", i), fill_level, tbl[i].e_fill);
         if (tbl[i].e_valid) chk($sformatf("vec%0d_data", i), av_src_data, tbl[i].e_data);
         readdata     = tbl[i].rd;
         waitrequest  = tbl[i].wr;
         av_src_ready = tbl[i].rdy;
         @(negedge clock);
      end

      // Backpressure until full, then a single pop.
      do_reset(8'h10, 1);
      repeat (40) slave_cycle();
      chk("full_reads", acc, 4);
      chk("full_fill", fill_level, 4);
      chk("full_read_low", read, 0);
      chk("full_head", av_src_data, 8'h10);
      av_src_ready = 1'b1;
      slave_cycle();
      av_src_ready = 1'b0;
      chk("pop_fill", fill_level, 3);
      chk("pop_head", av_src_data, 8'h11);
      chk("pop_read_n1", read, 0);
      slave_cycle();
      chk("pop_read_n2", read, 1);
      chk("pop_reads", acc, 5);

      // Simultaneous push/pop at fill 2, then 20-byte stream across pointer wrap.
      do_reset(8'h20, 1);
      found = 0;
      for (int g = 0; g < 30 && !found; g++) begin
         slave_cycle();
         if (fill_level == 3'd2 && read) found = 1;
      end
      chk("pp_reached", found, 1);
      av_src_ready = 1'b1;
      rec[0] = av_src_data;
      slave_cycle();
      av_src_ready = 1'b0;
      chk("pp_fill", fill_level, 2);
      chk("pp_head", av_src_data, 8'h21);
      av_src_ready = 1'b1;
      n = 1; guard = 0;
      while (n < 20 && guard < 200) begin
         if (av_src_valid) begin
            rec[n] = av_src_data;
            n++;
         end
         slave_cycle();
         guard++;
      end
      chk("stream_count", n, 20);
      for (int i = 0; i < n; i++) chk($sformatf("stream%0d", i), rec[i], 8'h20 + 8'(i));

      // Empty polling forever.
      do_reset(8'h00, 0);
      av_src_ready = 1'b1;
      starts = 0; last_start = 0; vcount = 0; prev_read = 0;
      for (int c = 1; c <= 120; c++) begin
         slave_cycle();
         if (av_src_valid) vcount++;
         if (prev_read) chk($sformatf("poll_width_c%0d", c), read, 0);
         if (read && !prev_read) begin
            starts++;
            if (last_start > 0) chk($sformatf("poll_spacing_c%0d", c), c - last_start, 18);
            last_start = c;
         end
         prev_read = read;
      end
      chk("poll_starts", starts, 7);
      chk("poll_valid_seen", vcount, 0);

      // Asynchronous reset mid-READ_WAIT with 3 bytes buffered.
      do_reset(8'h30, 1);
      found = 0;
      for (int g = 0; g < 30 && !found; g++) begin
         slave_cycle();
         if (fill_level == 3'd3 && read) found = 1;
      end
      chk("ar_reached", found, 1);
      waitrequest = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("ar_read", read, 0);
      chk("ar_valid", av_src_valid, 0);
      chk("ar_fill", fill_level, 0);
      @(negedge clock);
      waitrequest = 1'b0;
      readdata    = 32'h0;
      reset_n     = 1'b1;
      chk("ar_release_read", read, 0);
      found = 0;
      for (int g = 0; g < 2 && !found; g++) begin
         @(negedge clock);
         if (read) found = 1;
      end
      chk("ar_resume", found, 1);
      chk("ar_resume_fill", fill_level, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
